// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receive path: FSM state encoding,
// oversampling ratio and the baud tick divider calculation.
package rv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } uart_rx_state_t;

    localparam int UART_OVERSAMPLE = 16;

    // Clocks per oversample tick, truncated, never below one.
    function automatic int tick_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * UART_OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// First-word-fall-through byte buffer for the UART receiver. The head word is
// read combinationally from the registered array; push/pop act at the clock edge.
module rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty,
    output logic                     o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign o_empty = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot a push into a full buffer needs.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!full || do_pop);
    assign o_drop  = i_push && full && !do_pop;

    assign o_count = wr_ptr_q - rd_ptr_q;
    assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with 16x
// oversampling, feeding a FWFT byte FIFO read by the memory stage.
module uart_rx_fifo
    import rv_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_rx,
    input  logic                          i_rd,
    input  logic                          i_clr_err,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          o_parity_err,
`endif
    output logic                          o_frame_err
);

    localparam int             DIV       = tick_div(CLK_HZ, BAUD);
    localparam int             TW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(DIV - 1);
    localparam logic [3:0]     HALF_LAST = 4'(UART_OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     FULL_LAST = 4'(UART_OVERSAMPLE - 1);

    logic           rx_meta_q, rx_meta_d;
    logic           rx_s_q, rx_s_d;
    uart_rx_state_t state_q, state_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [3:0]     sample_cnt_q, sample_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           frame_err_q, frame_err_d;
    logic           overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic           parity_bad_q, parity_bad_d;
    logic           parity_err_q, parity_err_d;
    logic           parity_set;
`endif

    logic tick;
    logic push;
    logic frame_set;
    logic fifo_empty;
    logic fifo_drop;

    assign tick = (state_q != IDLE) && (tick_cnt_q == TICK_LAST);

    always_comb begin
        rx_meta_d    = i_rx;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        tick_cnt_d   = '0;
        sample_cnt_d = sample_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        push         = 1'b0;
        frame_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_bad_d = parity_bad_q;
        parity_set   = 1'b0;
`endif
        if (state_q != IDLE && tick_cnt_q != TICK_LAST) tick_cnt_d = tick_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                sample_cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            // Re-check the line mid start bit so short low glitches are dropped.
            START: if (tick) begin
                if (sample_cnt_q == HALF_LAST) begin
                    sample_cnt_d = '0;
                    bit_idx_d    = '0;
                    state_d      = rx_s_q ? IDLE : DATA;
                end else begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                end
            end
            DATA: if (tick) begin
                sample_cnt_d = sample_cnt_q + 1'b1;
                if (sample_cnt_q == FULL_LAST) begin
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                sample_cnt_d = sample_cnt_q + 1'b1;
                if (sample_cnt_q == FULL_LAST) begin
                    parity_bad_d = ^{shift_q, rx_s_q};
                    parity_set   = ^{shift_q, rx_s_q};
                    state_d      = STOP;
                end
            end
`endif
            STOP: if (tick) begin
                sample_cnt_d = sample_cnt_q + 1'b1;
                if (sample_cnt_q == FULL_LAST) begin
                    state_d = IDLE;
                    if (!rx_s_q) begin
                        frame_set = 1'b1;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        push = !parity_bad_q;
`else
                        push = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An error event in the same cycle as a clear keeps the flag set.
        frame_err_d  = (frame_err_q & ~i_clr_err) | frame_set;
        overrun_d    = (overrun_q & ~i_clr_err) | fifo_drop;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (parity_err_q & ~i_clr_err) | parity_set;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= IDLE;
            tick_cnt_q   <= '0;
            sample_cnt_q <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_bad_q <= parity_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_wdata (shift_q),
        .i_pop   (i_rd),
        .o_rdata (o_data),
        .o_count (o_count),
        .o_empty (fifo_empty),
        .o_drop  (fifo_drop)
    );

    assign o_valid     = !fifo_empty;
    assign o_overrun   = overrun_q;
    assign o_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a vector table, hand-written corner
// sequences and randomized frames checked against a queue-based model.
module tb_uart_rx_fifo;

    localparam int CLK_HZ   = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 16;
    localparam int BIT_CLKS = CLK_HZ / BAUD;

    typedef enum int {OP_SEND, OP_POP, OP_CLR} op_e;

    typedef struct {
        op_e        op;
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [4:0] exp_count;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd;
    logic       clr;
    logic [7:0] data;
    logic       valid;
    logic [4:0] count;
    logic       ovr;
    logic       ferr;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] model_q[$];
    logic       m_ferr;
    logic       m_ovr;
    vec_t       vecs[11];
    int         lat;
    logic       seen;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .i_rd         (rd),
        .i_clr_err    (clr),
        .o_data       (data),
        .o_valid      (valid),
        .o_count      (count),
        .o_overrun    (ovr),
`ifdef UART_RX_PARITY_EN
        .o_parity_err (perr),
`endif
        .o_frame_err  (ferr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] head;
        head = (model_q.size() > 0) ? model_q[0] : 8'h00;
        chk({tag, "_valid"}, 32'(valid), 32'(model_q.size() > 0));
        chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
        chk({tag, "_data"},  32'(data),  32'(head));
        chk({tag, "_ferr"},  32'(ferr),  32'(m_ferr));
        chk({tag, "_ovr"},   32'(ovr),   32'(m_ovr));
        $display("txn %-12s count=%0d data=%02h ferr=%0b ovr=%0b", tag, count, data, ferr, ovr);
    endtask

    // Reference: a completed frame either flags a bad stop bit, overflows, or queues.
    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop)                        m_ferr = 1'b1;
        else if (model_q.size() >= DEPTH) m_ovr  = 1'b1;
        else                              model_q.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pop_one();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic clear_err();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_SEND, 8'h55, 1'b1, 1'b1, 5'd1, 8'h55, 1'b0, 1'b0};
        vecs[1]  = '{OP_POP,  8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{OP_SEND, 8'hA5, 1'b1, 1'b1, 5'd1, 8'hA5, 1'b0, 1'b0};
        vecs[3]  = '{OP_SEND, 8'h3C, 1'b1, 1'b1, 5'd2, 8'hA5, 1'b0, 1'b0};
        vecs[4]  = '{OP_SEND, 8'hFF, 1'b1, 1'b1, 5'd3, 8'hA5, 1'b0, 1'b0};
        vecs[5]  = '{OP_POP,  8'h00, 1'b1, 1'b1, 5'd2, 8'h3C, 1'b0, 1'b0};
        vecs[6]  = '{OP_POP,  8'h00, 1'b1, 1'b1, 5'd1, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{OP_POP,  8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{OP_SEND, 8'h81, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{OP_CLR,  8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{OP_POP,  8'h00, 1'b1, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0};

        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        rst = 1'b1; rx = 1'b1; rd = 1'b0; clr = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_model("reset");

        // Table: single byte, back-to-back frames, frame error, clear, empty read.
        for (int i = 0; i < 11; i++) begin
            case (vecs[i].op)
                OP_SEND: begin
                    send_frame(vecs[i].data, vecs[i].stop);
                    model_frame(vecs[i].data, vecs[i].stop);
                end
                OP_POP:  pop_one();
                default: clear_err();
            endcase
            chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_data", i),  32'(data),  32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_ferr", i),  32'(ferr),  32'(vecs[i].exp_ferr));
            chk($sformatf("vec%0d_ovr", i),   32'(ovr),   32'(vecs[i].exp_ovr));
            $display("txn vec%0d op=%0d count=%0d data=%02h ferr=%0b ovr=%0b",
                     i, vecs[i].op, count, data, ferr, ovr);
        end
        idle(40);

        // Latency: o_valid must rise within 10 bit times plus 4 clocks of the start edge.
        fork
            send_frame(8'h55, 1'b1);
            begin
                lat = 0;
                while (!valid && lat < 10 * BIT_CLKS + 4) begin
                    @(negedge clk);
                    lat++;
                end
                seen = valid;
            end
        join
        chk("latency_valid", 32'(seen), 32'd1);
        model_frame(8'h55, 1'b1);
        check_model("latency");
        pop_one();
        check_model("latency_pop");
        idle(40);

        // Short low glitch on the idle line must not start a frame.
        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(60);
        check_model("glitch");
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1);
        check_model("post_glitch");
        pop_one();
        check_model("post_glitch_pop");

        // Overflow: 17 frames into a 16-deep buffer.
        for (int b = 0; b < 17; b++) begin
            send_frame(8'(b), 1'b1);
            model_frame(8'(b), 1'b1);
        end
        check_model("ovr_full");
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("ovr_pop%0d", i), 32'(data), 32'(i));
            pop_one();
        end
        check_model("ovr_drained");
        clear_err();
        check_model("ovr_clr");
        idle(40);

        // Reset in the middle of a frame flushes the buffer and abandons the frame.
        send_frame(8'h11, 1'b1);
        model_frame(8'h11, 1'b1);
        check_model("pre_rst");
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 8'h42 >> i;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        idle(40);
        check_model("rst_mid");
        send_frame(8'h99, 1'b1);
        model_frame(8'h99, 1'b1);
        check_model("rst_after");
        pop_one();
        check_model("rst_after_pop");

        // Randomized frames, pops and clears against the queue model.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            logic       stop;
            int         npop;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 9) != 0);
            send_frame(b, stop);
            model_frame(b, stop);
            check_model($sformatf("rnd%0d", n));
            if (!stop) idle(40);
            npop = $urandom_range(0, 2);
            for (int p = 0; p < npop; p++) begin
                pop_one();
                check_model($sformatf("rnd%0d_pop", n));
            end
            if ($urandom_range(0, 7) == 0) begin
                clear_err();
                check_model($sformatf("rnd%0d_clr", n));
            end
        end
        for (int i = 0; i < DEPTH + 1 && model_q.size() > 0; i++) begin
            pop_one();
            check_model("drain");
        end
        pop_one();
        check_model("drain_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver feeding the memory stage's UART MMIO read path.
- Samples the raw `i_uart_rx` pin, deserialises 8N1 frames and buffers received bytes in a first-word-fall-through FIFO.
- The memory stage pops bytes on an MMIO read of the RX data register.
- Exposes error/status flags for the UART status register.

Parameters:
- CLK_HZ, 50_000_000, core clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- FIFO_DEPTH, 16, RX buffer entries; power of two, >= 2.

Ports:
- i_clk  in  1  core clock.
- i_rst  in  1  synchronous reset, active-high.
- i_rx  in  1  asynchronous serial line, idle high.
- i_rd  in  1  pop strobe from the memory stage; one byte popped per cycle high.
- i_clr_err  in  1  clears o_overrun and o_frame_err.
- o_data  out  8  byte at FIFO head; valid when o_valid = 1.
- o_valid  out  1  FIFO non-empty.
- o_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- o_overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- o_frame_err  out  1  sticky: a stop bit sampled low.

Behaviour:
- Reset: FSM to IDLE, FIFO empty, sync flops to 1.
  - Outputs: o_valid = 0, o_count = 0, o_data = 0, o_overrun = 0, o_frame_err = 0.
- Input sync: 2-flop synchroniser on i_rx; all logic uses the second flop (rx_s).
- Tick generator: DIV = CLK_HZ / (BAUD*16), integer truncation, minimum 1.
  - Counter 0..DIV-1 emits a 1-cycle `tick` at wrap.
  - Runs free while the FSM is not IDLE; held at 0 in IDLE.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: rx_s = 0 -> START, tick counter and sample counter cleared.
  - START: at the 8th tick, rx_s = 1 -> IDLE (glitch rejected); rx_s = 0 -> DATA, sample counter cleared.
  - DATA: every 16th tick, sample rx_s into shift[bit_idx], LSB first. After bit 7 -> STOP.
  - STOP: at the 16th tick, sample the stop bit, then -> IDLE.
    - Stop bit 1: push the byte into the FIFO.
    - Stop bit 0: set o_frame_err and discard the byte.
- A new start bit is detectable in the cycle after STOP -> IDLE; back-to-back frames must not be lost.
- FIFO (first-word-fall-through):
  - o_data reflects the head combinationally from the registered memory/pointers.
  - Push and pop take effect at the clock edge.
  - Latency: push at edge N -> o_valid = 1 after edge N.
  - Pointers have width $clog2(FIFO_DEPTH)+1 and wrap naturally. Full = MSBs differ and LSBs equal.
- i_rd while empty: ignored; no pointer change, no error.
- Push while full: byte dropped, o_overrun set, FIFO contents unchanged.
- Push and pop in the same cycle:
  - Both occur and count is unchanged.
  - When full, the pop frees a slot, so the push succeeds with no overrun.
- i_clr_err and an error event in the same cycle: set wins, flag stays 1.
- i_rst mid-frame: the frame is abandoned and the FIFO flushed; reception resumes on the next falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP; the frame format becomes 8E1.
  - Even-parity mismatch sets a sticky o_parity_err output (1 bit), cleared by i_clr_err.
  - A byte with a parity error is discarded.
- When undefined: o_parity_err port absent, no PARITY state, format 8N1.

Decomposition:
- rv_pkg: enum uart_rx_state_t (IDLE, START, DATA, STOP, PARITY) and localparam UART_OVERSAMPLE = 16.
- Sub-module: rx_fifo, parameterised by DEPTH and WIDTH = 8, containing push, pop, count, full and empty.
  - uart_rx_fifo instantiates it and keeps the synchroniser, tick generator and FSM.

Test Plan (CLK_HZ = 3_200_000, BAUD = 100_000 -> DIV = 2, 32 clocks per bit):
- Reset, then send byte 0x55 -> o_valid rises within 10*32+4 clocks; o_data = 0x55, o_count = 1. Pulse i_rd -> o_valid = 0, o_count = 0.
- Back-to-back bytes 0xA5, 0x3C, 0xFF with no idle gap -> popped in order 0xA5, 0x3C, 0xFF; no errors.
- Low glitch of 5 clocks on idle line -> FSM returns to IDLE, o_count stays 0, no flags.
- Frame 0x81 with stop bit driven 0 -> o_frame_err = 1, o_count = 0. Pulse i_clr_err -> o_frame_err = 0.
- Send 17 bytes 0x00..0x10 without popping (DEPTH = 16) -> o_count = 16, o_overrun = 1; pops return 0x00..0x0F.
- Assert i_rst during DATA of byte 0x42, release, then send 0x99 -> only 0x99 received; o_count = 1.
